quad_decoder: RTL

- Upstream control stage for the up/down counters: `counter_behavioral`, `counter_jkff` and `counter_tff_sync`.
- Takes raw two-phase quadrature inputs (A/B) from an encoder or switch pair.
- Synchronizes and glitch-filters them, then decodes Gray-code transitions.
- Emits a single-cycle count strobe plus a direction bit that drive the counter's `en` and `count_up` directly. Illegal (double) transitions are flagged and tallied.

---
 rtl/quad_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//
// Front end for the up/down counters (counter_behavioral, counter_jkff,
// counter_tff_sync). Raw A/B quadrature inputs are synchronised, glitch
// filtered and decoded as Gray-code steps. Each valid step produces a
// one-cycle count strobe plus a direction bit that drive the counter's
// en / count_up inputs directly. Double-bit (illegal) transitions raise a
// sticky flag and are tallied in a saturating counter.
//
// Parameters
//   SYNC_STAGES  synchroniser flops per input channel (>= 2)
//   FILT         cycles a synced level must disagree with the filtered level
//                before it is accepted (1 = no filtering)
//   ERR_W        width of the saturating illegal-transition counter
//
// Ports
//   clk       in   system clock, rising edge
//   res       in   synchronous active-high reset
//   a_in      in   raw phase A, asynchronous to clk
//   b_in      in   raw phase B, asynchronous to clk
//   err_clr   in   clears err and err_cnt
//   en        out  one-cycle count strobe
//   count_up  out  direction of the last valid step (1 = up)
//   state     out  filtered {A,B}
//   err       out  sticky illegal-transition flag
//   err_cnt   out  saturating illegal-transition count
// -----------------------------------------------------------------------------
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 2,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             err_clr,
    output logic             en,
    output logic             count_up,
    output logic [1:0]       state,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int FCW = $clog2(FILT + 1);
    localparam int ICW = $clog2(SYNC_STAGES + 1);

    localparam logic [FCW-1:0]   FILT_END = FCW'(FILT);
    localparam logic [ICW-1:0]   INIT_END = ICW'(SYNC_STAGES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic {INIT, RUN} fsm_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILL
    } step_t;

    // Saturating increment of the illegal-transition tally.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

    // One filter update for a single channel. Returns {filtered bit, run count}.
    // The run count tracks how many consecutive cycles the synced level has
    // disagreed with the filtered level; any agreement restarts it.
    function automatic logic [FCW:0] filt_step(
        input logic           synced,
        input logic           filt,
        input logic [FCW-1:0] run
    );
        logic [FCW-1:0] nxt;
        if (synced == filt) begin
            return {filt, {FCW{1'b0}}};
        end
        nxt = run + FCW'(1);
        if (nxt == FILT_END) begin
            return {synced, {FCW{1'b0}}};
        end
        return {filt, nxt};
    endfunction

    // Classify the move from previous filtered state p to new state n.
    // Up order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
    function automatic step_t decode(input logic [1:0] p, input logic [1:0] n);
        case ({p, n})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return STEP_UP;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return STEP_DOWN;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: return STEP_ILL;
            default:                                return STEP_NONE;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_a_p0;
    logic [SYNC_STAGES-1:0] sync_b_p0;
    logic                   a_syn_p0;
    logic                   b_syn_p0;

    logic [FCW-1:0]         run_a_p1;
    logic [FCW-1:0]         run_b_p1;
    logic [1:0]             state_p1;
    logic [1:0]             prev_p1;
    logic                   vld_p1;

    fsm_t                   fsm;
    logic [ICW-1:0]         init_cnt;

    logic                   en_p2;
    logic                   up_p2;
    logic                   err_p2;
    logic [ERR_W-1:0]       err_cnt_p2;

    logic [FCW:0]           fa_nxt;
    logic [FCW:0]           fb_nxt;
    logic [1:0]             state_nxt;
    step_t                  step_p1;
    logic                   ill_p1;

    assign a_syn_p0 = sync_a_p0[SYNC_STAGES-1];
    assign b_syn_p0 = sync_b_p0[SYNC_STAGES-1];

    always_comb begin
        fa_nxt    = filt_step(a_syn_p0, state_p1[1], run_a_p1);
        fb_nxt    = filt_step(b_syn_p0, state_p1[0], run_b_p1);
        state_nxt = {fa_nxt[FCW], fb_nxt[FCW]};
        step_p1   = decode(prev_p1, state_p1);
        ill_p1    = (fsm == RUN) && vld_p1 && (step_p1 == STEP_ILL);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sync_a_p0  <= '0;
            sync_b_p0  <= '0;
            run_a_p1   <= '0;
            run_b_p1   <= '0;
            state_p1   <= 2'b00;
            prev_p1    <= 2'b00;
            vld_p1     <= 1'b0;
            fsm        <= INIT;
            init_cnt   <= '0;
            en_p2      <= 1'b0;
            up_p2      <= 1'b1;
            err_p2     <= 1'b0;
            err_cnt_p2 <= '0;
        end else begin
            // ---- stage p0: per-channel synchroniser chains ----
            sync_a_p0 <= {sync_a_p0[SYNC_STAGES-2:0], a_in};
            sync_b_p0 <= {sync_b_p0[SYNC_STAGES-2:0], b_in};

            en_p2  <= 1'b0;
            vld_p1 <= 1'b0;

            case (fsm)
                INIT: begin
                    // Let the synchronisers fill with real input levels, then
                    // adopt them as the starting state without decoding, so
                    // whatever the encoder rests at produces no en or err.
                    run_a_p1 <= '0;
                    run_b_p1 <= '0;
                    if (init_cnt == INIT_END) begin
                        state_p1 <= {a_syn_p0, b_syn_p0};
                        prev_p1  <= {a_syn_p0, b_syn_p0};
                        fsm      <= RUN;
                    end else begin
                        init_cnt <= init_cnt + ICW'(1);
                    end
                end

                RUN: begin
                    // ---- stage p1: glitch filter, filtered state register ----
                    run_a_p1 <= fa_nxt[FCW-1:0];
                    run_b_p1 <= fb_nxt[FCW-1:0];
                    prev_p1  <= state_p1;
                    state_p1 <= state_nxt;
                    vld_p1   <= (state_nxt != state_p1);

                    // ---- stage p2: decode the step that landed last cycle ----
                    if (vld_p1) begin
                        case (step_p1)
                            STEP_UP: begin
                                en_p2 <= 1'b1;
                                up_p2 <= 1'b1;
                            end
                            STEP_DOWN: begin
                                en_p2 <= 1'b1;
                                up_p2 <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                default: fsm <= INIT;
            endcase

            // An illegal step in the same cycle as a clear counts as the first
            // error after the clear.
            if (ill_p1) begin
                err_p2     <= 1'b1;
                err_cnt_p2 <= err_clr ? ERR_W'(1) : sat_inc(err_cnt_p2);
            end else if (err_clr) begin
                err_p2     <= 1'b0;
                err_cnt_p2 <= '0;
            end
        end
    end

    assign en       = en_p2;
    assign count_up = up_p2;
    assign state    = state_p1;
    assign err      = err_p2;
    assign err_cnt  = err_cnt_p2;

endmodule
